// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package rr_mux_arbiter_pkg;

  localparam int DEF_WIDTH = 4;

  // Requester index, doubles as the 2:1 mux select.
  typedef logic req_idx_t;
  localparam req_idx_t REQ0 = 1'b0;
  localparam req_idx_t REQ1 = 1'b1;

  // Output-register occupancy; the encoding is the out_valid bit itself.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle: two requester channels plus the registered output channel.
interface rr_mux_arbiter_if #(
  parameter int WIDTH = rr_mux_arbiter_pkg::DEF_WIDTH
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             ack0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             ack1;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             sel;

  // Environment side: producers and the downstream consumer.
  modport master (
    output req0, data0, req1, data1, out_ready,
    input  ack0, ack1, out_valid, out_data, sel
  );

  // Arbiter side.
  modport slave (
    input  req0, data0, req1, data1, out_ready,
    output ack0, ack1, out_valid, out_data, sel
  );
endinterface

// File: rtl/rr_mux_arbiter_pick2.sv
// Combinational two-way round-robin pick. prio names the index that wins a tie.
module rr_pick2
  import rr_mux_arbiter_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  req_idx_t prio,
  input  logic     en,
  output req_idx_t winner,
  output logic     ack0,
  output logic     ack1
);

  // Tie goes to prio; otherwise whichever requester is asking.
  always_comb begin
    winner = REQ0;
    if (req0 && req1) winner = prio;
    else if (req1)    winner = REQ1;
  end

  // en already implies at least one request, but gating on reqN keeps
  // the acks one-hot and tied to a real request.
  assign ack0 = en & req0 & (winner == REQ0);
  assign ack1 = en & req1 & (winner == REQ1);

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter steering two producers through a 2:1 mux into a
// single registered valid/ready output stage.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
)(
  input  logic               clk,
  input  logic               rst,
  rr_mux_arbiter_if.slave    bus
);

  state_t           state;
  req_idx_t         prio;
  req_idx_t         winner;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] mux_out;
  logic [WIDTH-1:0] data_q;
  req_idx_t         sel_q;

  // Load whenever someone asks and the output slot is free or draining.
  // Reset suppresses loads so no ack is seen during the reset cycle.
  assign load = (bus.req0 | bus.req1) & ((state == EMPTY) | bus.out_ready) & ~rst;
  assign xfer = (state == FULL) & bus.out_ready;

  rr_pick2 u_pick (
    .req0   (bus.req0),
    .req1   (bus.req1),
    .prio   (prio),
    .en     (load),
    .winner (winner),
    .ack0   (bus.ack0),
    .ack1   (bus.ack1)
  );

  // 2:1 mux: a=data0, b=data1, select = winner.
  assign mux_out = (winner == REQ1) ? bus.data1 : bus.data0;

  // Output register, occupancy FSM and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      data_q <= '0;
      sel_q  <= REQ0;
      prio   <= REQ0;
    end else begin
      case (state)
        EMPTY: if (load) state <= FULL;
        FULL:  if (xfer && !load) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      if (load) begin
        data_q <= mux_out;
        sel_q  <= winner;
        prio   <= ~winner;
      end
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_q;
  assign bus.sel       = sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: reset, fairness, single, drain,
// backpressure and mid-operation reset.
module tb_rr_mux_arbiter;
  import rr_mux_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  rr_mux_arbiter_if #(.WIDTH(4)) bus ();

  rr_mux_arbiter #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.data0 = 4'h1; bus.data1 = 4'h2;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({bus.ack0, bus.ack1} !== 2'b00) begin
        bad++; $display("FAIL reset_ack[%0d]: got %b want 00", i, {bus.ack0, bus.ack1});
      end
      total++;
      if ({bus.out_valid, bus.out_data, bus.sel} !== {1'b0, 4'h0, 1'b0}) begin
        bad++; $display("FAIL reset_out[%0d]: got v=%b d=%h s=%b want v=0 d=0 s=0",
                        i, bus.out_valid, bus.out_data, bus.sel);
      end
    end
    rst = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  task automatic test_tie();
    logic [3:0] exp_d;
    logic       exp_s;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.data0 = 4'h0; bus.data1 = 4'hF;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_s = (i % 2 == 1);
      exp_d = exp_s ? 4'hF : 4'h0;
      #1;
      total++;
      if ({bus.ack0, bus.ack1} !== {~exp_s, exp_s}) begin
        bad++; $display("FAIL tie_ack[%0d]: got %b want %b", i, {bus.ack0, bus.ack1}, {~exp_s, exp_s});
      end
      tick();
      total++;
      if ({bus.out_valid, bus.out_data, bus.sel} !== {1'b1, exp_d, exp_s}) begin
        bad++; $display("FAIL tie_out[%0d]: got v=%b d=%h s=%b want v=1 d=%h s=%b",
                        i, bus.out_valid, bus.out_data, bus.sel, exp_d, exp_s);
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  task automatic test_single();
    bus.req0 = 1'b1; bus.data0 = 4'h3; bus.out_ready = 1'b1;
    #1;
    total++;
    if ({bus.ack0, bus.ack1} !== 2'b10) begin
      bad++; $display("FAIL single_ack: got %b want 10", {bus.ack0, bus.ack1});
    end
    tick();
    total++;
    if ({bus.out_valid, bus.out_data, bus.sel} !== {1'b1, 4'h3, 1'b0}) begin
      bad++; $display("FAIL single_out: got v=%b d=%h s=%b want v=1 d=3 s=0",
                      bus.out_valid, bus.out_data, bus.sel);
    end
    bus.req0 = 1'b0;
  endtask

  task automatic test_drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if ({bus.ack0, bus.ack1} !== 2'b00) begin
        bad++; $display("FAIL drain_ack[%0d]: got %b want 00", i, {bus.ack0, bus.ack1});
      end
      tick();
      total++;
      if ({bus.out_valid, bus.out_data, bus.sel} !== {1'b0, 4'h3, 1'b0}) begin
        bad++; $display("FAIL drain_out[%0d]: got v=%b d=%h s=%b want v=0 d=3 s=0",
                        i, bus.out_valid, bus.out_data, bus.sel);
      end
    end
  endtask

  task automatic test_backpressure();
    // Fill the output slot with 7 while the consumer is stalled.
    bus.req0 = 1'b1; bus.data0 = 4'h7; bus.out_ready = 1'b0;
    tick();
    total++;
    if ({bus.out_valid, bus.out_data, bus.sel} !== {1'b1, 4'h7, 1'b0}) begin
      bad++; $display("FAIL bp_fill: got v=%b d=%h s=%b want v=1 d=7 s=0",
                      bus.out_valid, bus.out_data, bus.sel);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.data1 = 4'hA;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({bus.ack0, bus.ack1} !== 2'b00) begin
        bad++; $display("FAIL bp_stall_ack[%0d]: got %b want 00", i, {bus.ack0, bus.ack1});
      end
      tick();
      total++;
      if ({bus.out_valid, bus.out_data, bus.sel} !== {1'b1, 4'h7, 1'b0}) begin
        bad++; $display("FAIL bp_stall_out[%0d]: got v=%b d=%h s=%b want v=1 d=7 s=0",
                        i, bus.out_valid, bus.out_data, bus.sel);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    total++;
    if ({bus.ack0, bus.ack1} !== 2'b01) begin
      bad++; $display("FAIL bp_release_ack: got %b want 01", {bus.ack0, bus.ack1});
    end
    tick();
    total++;
    if ({bus.out_valid, bus.out_data, bus.sel} !== {1'b1, 4'hA, 1'b1}) begin
      bad++; $display("FAIL bp_release_out: got v=%b d=%h s=%b want v=1 d=a s=1",
                      bus.out_valid, bus.out_data, bus.sel);
    end
    bus.req1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    // Load 5 from requester 0 (transfer + load, no bubble); prio becomes 1.
    bus.req0 = 1'b1; bus.data0 = 4'h5; bus.out_ready = 1'b1;
    tick();
    total++;
    if ({bus.out_valid, bus.out_data, bus.sel} !== {1'b1, 4'h5, 1'b0}) begin
      bad++; $display("FAIL mid_load: got v=%b d=%h s=%b want v=1 d=5 s=0",
                      bus.out_valid, bus.out_data, bus.sel);
    end
    // Both request and consumer stalls, then reset for one cycle.
    bus.req1 = 1'b1; bus.data0 = 4'h6; bus.data1 = 4'h9; bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.ack0, bus.ack1} !== 2'b00) begin
      bad++; $display("FAIL mid_rst_ack: got %b want 00", {bus.ack0, bus.ack1});
    end
    tick();
    total++;
    if ({bus.out_valid, bus.out_data, bus.sel} !== {1'b0, 4'h0, 1'b0}) begin
      bad++; $display("FAIL mid_rst_out: got v=%b d=%h s=%b want v=0 d=0 s=0",
                      bus.out_valid, bus.out_data, bus.sel);
    end
    rst = 1'b0; bus.out_ready = 1'b1;
    #1;
    total++;
    if ({bus.ack0, bus.ack1} !== 2'b10) begin
      bad++; $display("FAIL mid_retry_ack: got %b want 10", {bus.ack0, bus.ack1});
    end
    tick();
    total++;
    if ({bus.out_valid, bus.out_data, bus.sel} !== {1'b1, 4'h6, 1'b0}) begin
      bad++; $display("FAIL mid_retry_out: got v=%b d=%h s=%b want v=1 d=6 s=0",
                      bus.out_valid, bus.out_data, bus.sel);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_tie();
    test_single();
    test_drain();
    test_backpressure();
    test_reset_mid();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
